// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path (and a future receiver).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with occupancy count and synchronous flush.
// Latency: a push is visible on empty_o/count_o/head_dat_o one clock after the push edge.
// Backpressure: pushes while full are ignored unless a pop happens on the same edge.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush_i           empties the FIFO; overrides push and pop on the same edge
//   push_i/push_dat_i write request and data
//   pop_i             removes the head entry (ignored while empty)
//   head_dat_o        current head entry (valid while !empty_o)
//   full_o/empty_o    occupancy flags, derived from the registered count
//   count_o           number of stored entries
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rptr_q];

    // A pop on the same edge frees a slot, so a push into a full FIFO is still taken.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + AW'(1);
            if (pop_ok)  rptr_d = rptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: buffers CPU byte writes in a FIFO and shifts them out on tx_o.
// Latency: write at edge E0 -> start bit driven after E1 (2 clocks); frames run back-to-back.
// Backpressure: none toward the CPU; writes while full are dropped and flagged in overflow.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   uart_we       push data_in into the FIFO
//   uart_clear    flush pending bytes and clear overflow (wins over uart_we)
//   data_in       byte to transmit
//   tx_o          serial line, idles high, driven straight from a flop
//   busy          a frame is in progress
//   full, empty   FIFO status
//   count         bytes pending, not counting the frame on the wire
//   overflow      sticky: a write was dropped
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_we,
    input  logic                          uart_clear,
    input  logic [7:0]                    data_in,
    output logic                          tx_o,
    output logic                          busy,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    uart_tx_state_t                state_q, state_d;
    logic [CNT_W-1:0]              baud_cnt_q, baud_cnt_d;
    logic [2:0]                    bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0]     shift_q, shift_d;
    logic                          tx_q, tx_d;
    logic                          overflow_q, overflow_d;

    logic                          fifo_pop;
    logic                          fifo_push;
    logic [UART_DATA_BITS-1:0]     fifo_head;
    logic                          bit_end;
    logic                          start_ok;
    logic                          drop;

    // A clear in the same cycle also cancels the write.
    assign fifo_push = uart_we && !uart_clear;
    // Dropped writes are those the FIFO will refuse: full with no pop to make room.
    assign drop      = fifo_push && full && !fifo_pop;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (uart_clear),
        .push_i     (fifo_push),
        .push_dat_i (data_in),
        .pop_i      (fifo_pop),
        .head_dat_o (fifo_head),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count)
    );

    assign bit_end  = (baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    // A byte being flushed this cycle must not be launched.
    assign start_ok = !empty && !uart_clear;

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + CNT_W'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                tx_d       = UART_STOP_LVL;
                if (start_ok) begin
                    state_d  = START;
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    tx_d     = UART_START_LVL;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d    = DATA;
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    tx_d       = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
                        state_d = STOP;
                        tx_d    = UART_STOP_LVL;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        // tx_d leads the shift by one bit so the line changes on this edge.
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (start_ok) begin
                        // Next start bit follows the stop bit with no idle gap.
                        state_d  = START;
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        tx_d     = UART_START_LVL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = UART_STOP_LVL;
            end
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (uart_clear) overflow_d = 1'b0;
        else if (drop)  overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= UART_STOP_LVL;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_o     = tx_q;
    assign busy     = (state_q != IDLE);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

    localparam int CLK_FREQ_HZ = 1000;
    localparam int BAUD        = 100;
    localparam int FIFO_DEPTH  = 16;
    localparam int CPB         = CLK_FREQ_HZ / BAUD;
    localparam int FRAME       = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_we = 1'b0;
    logic       uart_clear = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx_o, busy, full, empty, overflow;
    logic [4:0] count;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: bytes the line must carry, in order.
    byte unsigned exp_q[$];
    // Line decoder output: bytes seen on tx_o, and the cycle each frame started.
    byte unsigned rx_q[$];
    int           start_q[$];

    uart_tx_serializer #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD        (BAUD),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_we    (uart_we),
        .uart_clear (uart_clear),
        .data_in    (data_in),
        .tx_o       (tx_o),
        .busy       (busy),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent line receiver: samples each bit at its centre relative to the falling start edge.
    int         cyc = 0;
    bit         in_frame = 1'b0;
    int         ofs = 0;
    int         fstart = 0;
    logic [9:0] fbits = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame) begin
                if (tx_o == 1'b0) begin
                    in_frame = 1'b1;
                    ofs      = 0;
                    fstart   = cyc;
                end
            end else begin
                ofs++;
            end
            if (in_frame && (ofs % CPB) == CPB / 2) fbits[ofs / CPB] = tx_o;
            if (in_frame && ofs == FRAME - 1) begin
                in_frame = 1'b0;
                chk("framing_start_stop", 32'({fbits[9], fbits[0]}), 32'h2);
                rx_q.push_back(fbits[8:1]);
                start_q.push_back(fstart);
            end
        end
    end

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        uart_we = 1'b1;
        data_in = b;
        @(negedge clk);
        uart_we = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy || !empty) && n < limit) begin
            n++;
            @(negedge clk);
        end
        chk("idle_within_budget", 32'(n < limit), 32'd1);
        ticks(3);
    endtask

    task automatic check_stream(input string tag);
        int n;
        chk({tag, "_frames"}, 32'(rx_q.size()), 32'(exp_q.size()));
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
        start_q.delete();
    endtask

    initial begin
        logic [7:0] v;
        int         n;
        int         low;

        // Reset state
        ticks(2);
        chk("rst_tx", 32'(tx_o), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        ticks(2);

        // Single byte: 2-clock start latency, 100-clock busy window
        push(8'h55);
        exp_q.push_back(8'h55);
        chk("single_count_after_write", 32'(count), 32'd1);
        chk("single_empty_after_write", 32'(empty), 32'd0);
        chk("single_tx_still_high", 32'(tx_o), 32'd1);
        ticks(1);
        chk("single_tx_start", 32'(tx_o), 32'd0);
        chk("single_busy_rise", 32'(busy), 32'd1);
        chk("single_count_after_pop", 32'(count), 32'd0);
        n = 0;
        while (busy && n < 300) begin
            n++;
            ticks(1);
        end
        chk("single_busy_clocks", 32'(n), 32'(FRAME));
        ticks(3);
        check_stream("single");

        // Back-to-back: second write coincides with the first pop
        push(8'hA3);
        exp_q.push_back(8'hA3);
        chk("b2b_count_1", 32'(count), 32'd1);
        push(8'h0F);
        exp_q.push_back(8'h0F);
        chk("b2b_count_push_pop", 32'(count), 32'd1);
        ticks(FRAME - 1);
        chk("b2b_count_before_2nd", 32'(count), 32'd1);
        ticks(1);
        chk("b2b_count_after_2nd", 32'(count), 32'd0);
        chk("b2b_tx_2nd_start", 32'(tx_o), 32'd0);
        chk("b2b_busy_held", 32'(busy), 32'd1);
        wait_idle(400);
        if (start_q.size() == 2) chk("b2b_no_gap", 32'(start_q[1] - start_q[0]), 32'(FRAME));
        else chk("b2b_frame_starts", 32'(start_q.size()), 32'd2);
        check_stream("b2b");

        // Overflow: one frame in flight, 17 more writes, the last one dropped
        v = 8'($urandom);
        push(v);
        exp_q.push_back(v);
        ticks(1);
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            v = 8'($urandom);
            if (i < FIFO_DEPTH) exp_q.push_back(v);
            push(v);
        end
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_count", 32'(count), 32'(FIFO_DEPTH));
        chk("ovf_flag", 32'(overflow), 32'd1);
        wait_idle((FIFO_DEPTH + 2) * FRAME);
        check_stream("ovf");
        chk("ovf_sticky", 32'(overflow), 32'd1);
        uart_clear = 1'b1;
        ticks(1);
        uart_clear = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Clear mid-frame with 3 bytes pending
        for (int i = 0; i < 4; i++) begin
            v = 8'($urandom);
            if (i == 0) exp_q.push_back(v);
            push(v);
        end
        chk("clr_pending", 32'(count), 32'd3);
        ticks(30);
        uart_clear = 1'b1;
        ticks(1);
        uart_clear = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_empty", 32'(empty), 32'd1);
        chk("clr_overflow", 32'(overflow), 32'd0);
        chk("clr_frame_continues", 32'(busy), 32'd1);
        wait_idle(2 * FRAME);
        low = 0;
        repeat (50) begin
            ticks(1);
            if (!tx_o) low++;
        end
        chk("clr_line_idle", 32'(low), 32'd0);
        check_stream("clr");

        // Clear and write in the same cycle
        uart_we    = 1'b1;
        data_in    = 8'h77;
        uart_clear = 1'b1;
        ticks(1);
        uart_we    = 1'b0;
        uart_clear = 1'b0;
        chk("clrwe_empty", 32'(empty), 32'd1);
        chk("clrwe_count", 32'(count), 32'd0);
        ticks(40);
        chk("clrwe_busy", 32'(busy), 32'd0);
        check_stream("clrwe");

        // Async reset during data bit 4 (chosen to be a 0 on the line)
        v = 8'($urandom) & 8'hEF;
        push(v);
        push(8'($urandom));
        chk("rst_mid_pending", 32'(count), 32'd1);
        ticks(CPB * 5 + 3);
        chk("rst_mid_bit4_low", 32'(tx_o), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_tx_immediate", 32'(tx_o), 32'd1);
        chk("rst_mid_busy_immediate", 32'(busy), 32'd0);
        ticks(2);
        rst = 1'b0;
        ticks(1);
        chk("rst_mid_busy_after", 32'(busy), 32'd0);
        chk("rst_mid_count_after", 32'(count), 32'd0);
        chk("rst_mid_tx_after", 32'(tx_o), 32'd1);
        ticks(30);
        check_stream("rst_mid");

        // Random bytes with random spacing
        repeat (6) begin
            v = 8'($urandom);
            exp_q.push_back(v);
            push(v);
            ticks($urandom_range(0, 150));
        end
        wait_idle(1200);
        check_stream("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
